// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised 2-write, N-read register file with bypass and pending scoreboard
module regfile_multiport #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int NUM_RD  = 6,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic                       we2,
  input  logic [ADDR_W-1:0]          waddr2,
  input  logic [DATA_W-1:0]          wdata2,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  output logic [(2**ADDR_W)-1:0]     pending_vec
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  assign pending_vec = pending;
  // Register and scoreboard update: port 2 beats port 1, a reservation beats a completing write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (R0_ZERO != 0 && i == 0) begin
          regs[i]    <= '0;
          pending[i] <= 1'b0;
        end else begin
          if (we2 && waddr2 == ADDR_W'(i)) regs[i] <= wdata2;
          else if (we1 && waddr1 == ADDR_W'(i)) regs[i] <= wdata1;
          pending[i] <= (rsv_en && rsv_addr == ADDR_W'(i)) ||
                        (pending[i] && !((we1 && waddr1 == ADDR_W'(i)) || (we2 && waddr2 == ADDR_W'(i))));
        end
      end
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic z, h1, h2;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    assign z  = (R0_ZERO != 0) && (ra == '0);
    assign h2 = (BYPASS != 0) && we2 && (waddr2 == ra);
    assign h1 = (BYPASS != 0) && we1 && (waddr1 == ra);
    assign rd_data[k*DATA_W +: DATA_W] = z ? '0 : h2 ? wdata2 : h1 ? wdata1 : regs[ra];
    assign rd_pending[k] = !z && !h1 && !h2 && pending[ra];
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed checks of a bypass DUT and a no-bypass, zero-r0 DUT sharing stimulus
module tb_regfile_multiport;
  logic clk = 1'b0;
  logic reset, we1, we2, rsv_en;
  logic [2:0] waddr1, waddr2, rsv_addr;
  logic [31:0] wdata1, wdata2;
  logic [17:0] rd_addr;
  logic [191:0] rd_a, rd_b;
  logic [5:0] rp_a, rp_b;
  logic [7:0] pv_a, pv_b;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_multiport u_a (
    .clk(clk), .reset(reset), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_a), .rd_pending(rp_a), .pending_vec(pv_a)
  );

  regfile_multiport #(.BYPASS(0), .R0_ZERO(1)) u_b (
    .clk(clk), .reset(reset), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_b), .rd_pending(rp_b), .pending_vec(pv_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we1 = 0; we2 = 0; rsv_en = 0; reset = 0;
  endtask

  task automatic set_rd(input logic [5:0][2:0] a);
    rd_addr = a;
  endtask

  task automatic all_zero(input string tag);
    set_rd({3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    #1;
    chk({tag, "_a_lo"}, {32'd0, rd_a[191:160] | rd_a[159:128] | rd_a[127:96] | rd_a[95:64] | rd_a[63:32] | rd_a[31:0]}, 64'd0);
    chk({tag, "_b_lo"}, {32'd0, rd_b[191:160] | rd_b[159:128] | rd_b[127:96] | rd_b[95:64] | rd_b[63:32] | rd_b[31:0]}, 64'd0);
    chk({tag, "_rp"}, {rp_a, rp_b}, 0);
    set_rd({3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd6});
    #1;
    chk({tag, "_a_hi"}, rd_a[63:0], 64'd0);
    chk({tag, "_b_hi"}, rd_b[63:0], 64'd0);
    chk({tag, "_pv"}, {pv_a, pv_b}, 0);
  endtask

  initial begin
    idle();
    reset = 1;
    waddr1 = 0; waddr2 = 0; rsv_addr = 0; wdata1 = 0; wdata2 = 0; rd_addr = 0;
    tick();
    tick();
    reset = 0;
    all_zero("reset");

    // test 1: fill regs 0..5 over three cycles
    for (int c = 0; c < 3; c++) begin
      we1 = 1; waddr1 = 3'(2 * c); wdata1 = 32'h10 + 32'(2 * c);
      we2 = 1; waddr2 = 3'(2 * c + 1); wdata2 = 32'h11 + 32'(2 * c);
      tick();
    end
    idle();
    set_rd({3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("fill_a%0d", k), rd_a[k*32 +: 32], 32'h10 + k);
      chk($sformatf("fill_b%0d", k), rd_b[k*32 +: 32], (k == 0) ? 0 : 32'h10 + k);
    end
    set_rd({3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd6});
    #1;
    chk("fill_r6_r7", rd_a[63:0], 0);

    // test 2: same-address conflict on reg 3
    set_rd({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3});
    we1 = 1; waddr1 = 3; wdata1 = 32'hAAAA_AAAA;
    we2 = 1; waddr2 = 3; wdata2 = 32'h5555_5555;
    #1;
    chk("conf_byp_a", rd_a[31:0], 32'h5555_5555);
    chk("conf_nobyp_b", rd_b[31:0], 32'h13);
    tick();
    idle();
    #1;
    chk("conf_a", rd_a[31:0], 32'h5555_5555);
    chk("conf_b", rd_b[31:0], 32'h5555_5555);

    // test 3: reserve reg 6, complete it three cycles later
    rsv_en = 1; rsv_addr = 6;
    tick();
    idle();
    set_rd({3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd0});
    #1;
    chk("rsv_pv_a", pv_a[6], 1);
    chk("rsv_pv_b", pv_b[6], 1);
    chk("rsv_rp_a", rp_a[1], 1);
    chk("rsv_rp_b", rp_b[1], 1);
    tick();
    tick();
    we1 = 1; waddr1 = 6; wdata1 = 32'h77;
    #1;
    chk("cmp_rp_a", rp_a[1], 0);
    chk("cmp_rd_a", rd_a[63:32], 32'h77);
    chk("cmp_rp_b", rp_b[1], 1);
    chk("cmp_rd_b", rd_b[63:32], 0);
    tick();
    idle();
    #1;
    chk("cmp_pv", {pv_a, pv_b}, 0);
    chk("cmp_rd_b_next", rd_b[63:32], 32'h77);

    // test 4: simultaneous reserve and write to reg 2
    we1 = 1; waddr1 = 2; wdata1 = 32'h22;
    rsv_en = 1; rsv_addr = 2;
    tick();
    idle();
    set_rd({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2});
    #1;
    chk("rw_pv", {pv_a, pv_b}, 16'h0404);
    chk("rw_rd", {rd_a[31:0], rd_b[31:0]}, {32'h22, 32'h22});
    chk("rw_rp", {rp_a[0], rp_b[0]}, 2'b11);

    // test 5: write and reserve reg 0
    we1 = 1; waddr1 = 0; wdata1 = 32'hDEAD;
    rsv_en = 1; rsv_addr = 0;
    set_rd({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0});
    #1;
    chk("r0_same_a", rd_a[31:0], 32'hDEAD);
    chk("r0_same_b", {rd_b[31:0], 31'd0, rp_b[0]}, 0);
    tick();
    idle();
    #1;
    chk("r0_rd_a", rd_a[31:0], 32'hDEAD);
    chk("r0_rd_b", rd_b[31:0], 0);
    chk("r0_rp", {rp_a[0], rp_b[0]}, 2'b10);
    chk("r0_pv", {pv_a, pv_b}, 16'h0504);

    // test 6: populate, reserve 3 and 5, then reset mid-stream with a write
    we1 = 1; waddr1 = 7; wdata1 = 32'h17;
    rsv_en = 1; rsv_addr = 3;
    tick();
    we1 = 0;
    rsv_addr = 5;
    tick();
    idle();
    set_rd({3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd7});
    #1;
    chk("pre_pv", {pv_a, pv_b}, 16'h2D2C);
    chk("pre_r7", rd_a[31:0], 32'h17);
    chk("pre_rp", {rp_a[1:0], rp_b[1:0]}, 4'b1010);
    reset = 1;
    we1 = 1; waddr1 = 1; wdata1 = 32'h99;
    rsv_en = 1; rsv_addr = 4;
    tick();
    idle();
    all_zero("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised multi-port register file that replaces the fixed 8x32, two-write/six-read register file in the datapath. Width, depth and read-port count are configurable. Adds optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard so that issue logic can stall on registers awaiting a multi-cycle result. Sits between decode (read addresses, reservations) and writeback (two write ports).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 6, number of combinational read ports
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored value only
R0_ZERO, 0, 1 = register 0 always reads 0, ignores writes and reservations

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all registers and pending bits
we1  in  1  write-port-1 enable
waddr1  in  ADDR_W  write-port-1 address
wdata1  in  DATA_W  write-port-1 data
we2  in  1  write-port-2 enable
waddr2  in  ADDR_W  write-port-2 address
wdata2  in  DATA_W  write-port-2 data
rsv_en  in  1  reserve request: mark rsv_addr pending
rsv_addr  in  ADDR_W  register to reserve
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
rd_pending  out  NUM_RD  per-read-port pending status of the addressed register
pending_vec  out  DEPTH  raw pending bit per register

Behaviour:
- Reset (reset=1 at clk edge): all registers = 0; all pending bits = 0. Reset overrides writes and reservations in the same cycle. After reset, rd_data = 0, rd_pending = 0, pending_vec = 0.
- Writes: at posedge, if we1, then reg[waddr1] <= wdata1; if we2, then reg[waddr2] <= wdata2. If both are enabled to the same address, port 2 wins. Write latency is 1 cycle.
- Reads: combinational, zero latency. An out-of-range read cannot occur because DEPTH = 2**ADDR_W.
- BYPASS=1: if we2 && waddr2==rd_addr[k], then rd_data[k] = wdata2. Else if we1 && waddr1==rd_addr[k], then rd_data[k] = wdata1. Else rd_data[k] = the stored value. Port-2 priority matches the write rule. BYPASS=0: stored value only; the new value is visible the cycle after the write.
- Scoreboard: at posedge, pending[a] is cleared if a write (either port) targets a, and then set if rsv_en && rsv_addr==a. When a reservation and a write hit the same register in the same cycle, the reservation wins and pending stays 1 (new producer issued). Reserving an already-pending register keeps it at 1. A write to a non-pending register is legal; pending stays 0.
- rd_pending[k] = pending[rd_addr[k]]. When BYPASS=1, rd_pending[k] also reads 0 if a same-cycle write matches rd_addr[k]; a same-cycle reservation does not affect rd_pending until the next cycle.
- R0_ZERO=1: reg[0] and pending[0] are held at 0. Writes and reservations to address 0 are discarded. Reads of address 0 return 0 with pending 0, including under bypass.
- No other state. No illegal states exist. Reset may assert mid-stream at any cycle; the next cycle shows fully cleared state regardless of prior pending bits.

Test Plan:
1. Reset, then with we1 writing regs 0,2,4 = 0x10,0x12,0x14 and we2 writing regs 1,3,5 = 0x11,0x13,0x15 over 3 cycles -> all 6 read ports (rd_addr=0..5) return 0x10..0x15, and regs 6 and 7 read 0.
2. Same-address conflict: we1 writes 0xAAAA_AAAA and we2 writes 0x5555_5555, both to reg 3, in one cycle -> the next cycle reg 3 reads 0x5555_5555. With BYPASS=1, the same cycle rd_addr=3 also reads 0x5555_5555; with BYPASS=0 it reads the old value.
3. Scoreboard: rsv_en on reg 6 -> pending_vec[6]=1 next cycle and rd_pending=1 on ports reading 6. Three cycles later, we1 writes 0x77 to reg 6 -> with BYPASS=1, rd_pending=0 and rd_data=0x77 in the same cycle; pending_vec[6]=0 next cycle.
4. Simultaneous reserve and write to reg 2 -> pending_vec[2]=1 after the edge and reg 2 holds the written data.
5. R0_ZERO=1: write 0xDEAD to reg 0 and reserve reg 0 -> reg 0 reads 0, pending_vec[0]=0, and rd_pending=0 for reads of address 0.
6. Set regs 1..7 nonzero and reserve regs 3 and 5, then assert reset for one cycle together with we1 to reg 1 -> all registers read 0 and pending_vec=0 the next cycle.
